fetch_stage: RTL



---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_stage_branch_target_calc.sv | 17 +
 rtl/fetch_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage: FSM states,
// the default NOP encoding and the branch-target arithmetic.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam int          MAX_ADDR_W        = 64;

    // Offsets are in words: sign-extend the selected field, scale by 4, add to
    // the branching PC. Callers narrower than 64 bits truncate the result.
    function automatic logic [MAX_ADDR_W-1:0] br_target(
        input logic [MAX_ADDR_W-1:0] pc,
        input logic                  uncond,
        input logic [25:0]           a26,
        input logic [18:0]           a19
    );
        logic [MAX_ADDR_W-1:0] off_words;
        off_words = uncond ? {{(MAX_ADDR_W-26){a26[25]}}, a26}
                           : {{(MAX_ADDR_W-19){a19[18]}}, a19};
        return pc + (off_words << 2);
    endfunction

endpackage

// File: rtl/fetch_stage_branch_target_calc.sv
// Combinational redirect-target generator: sign-extend, scale and add the
// decoder's branch offset to the branching instruction's PC.
module branch_target_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] br_pc,
    input  logic              uncond,
    input  logic [25:0]       braddr26,
    input  logic [18:0]       condaddr19,
    output logic [ADDR_W-1:0] target
);

    assign target = ADDR_W'(br_target(MAX_ADDR_W'(br_pc), uncond, braddr26, condaddr19));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, keeps at most one imem request outstanding and
// fills the IF/ID register. Define FETCH_PERF_EN for saturating perf counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              stall_in,
    input  logic              brtaken_in,
    input  logic              uncondbr_in,
    input  logic [25:0]       braddr26_in,
    input  logic [18:0]       condaddr19_in,
    input  logic [ADDR_W-1:0] br_pc_in,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              valid_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushes
`endif
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_out_q, pc_out_d, target;
    logic [31:0]       instr_q, instr_d, hold_q, hold_d;
    logic              valid_q, valid_d, drop_q, drop_d;
    logic              load, owed_next;

    branch_target_calc #(.ADDR_W(ADDR_W)) u_target (
        .br_pc      (br_pc_in),
        .uncond     (uncondbr_in),
        .braddr26   (braddr26_in),
        .condaddr19 (condaddr19_in),
        .target     (target)
    );

    // While a discarded response is still owed, no new request may go out.
    assign imem_req  = reset_n && (state_q == S_REQ) && !drop_q;
    assign imem_addr = pc_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
    assign valid_out = valid_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        hold_d   = hold_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        load     = 1'b0;

        // A response is owed after this edge if one was pending and did not
        // arrive now, or if a grant is being accepted now.
        owed_next = (((state_q == S_WAIT) || drop_q) && !imem_rvalid) || (imem_req && imem_gnt);

        if (!stall_in) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        if (brtaken_in) begin
            state_d = S_REQ;
            pc_d    = target;
            drop_d  = owed_next;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (drop_q) begin
                        if (imem_rvalid) drop_d = 1'b0;
                    end else if (imem_gnt) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (!valid_q || !stall_in) begin
                            load    = 1'b1;
                            instr_d = imem_rdata;
                        end else begin
                            hold_d  = imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!valid_q || !stall_in) begin
                        load    = 1'b1;
                        instr_d = hold_q;
                    end
                end
                default: state_d = S_REQ;
            endcase

            if (load) begin
                valid_d  = 1'b1;
                pc_out_d = pc_q;
                pc_d     = pc_q + ADDR_W'(4);
                state_d  = S_REQ;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            drop_q   <= owed_next;
            // NOTE: the hold buffer is cleared too; nothing reads it before a
            // capture, but a known value keeps it deterministic after reset.
            hold_q   <= '0;
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            hold_q   <= hold_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, flushes_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetched_q <= '0;
            flushes_q <= '0;
        end else begin
            if (load && (fetched_q != '1))       fetched_q <= fetched_q + 32'd1;
            if (brtaken_in && (flushes_q != '1)) flushes_q <= flushes_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushes = flushes_q;
`endif

endmodule
